// File: rtl/tlb_maint_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR: borrows the MMU search port, pulses
// CP0/TLB strobes in order, then waits a settle delay and requests a refetch.
module tlb_maint_ctrl #(
  parameter int TLBNUM       = 16,
  parameter int TLBNUM_WIDTH = $clog2(TLBNUM),
  parameter int WRITE_SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [1:0]              op_code,
  input  logic [31:0]             op_pc,
  output logic                    op_done,
  input  logic                    flush,
  output logic                    busy,
  input  logic [18:0]             entry_hi_vpn2,
  input  logic [7:0]              entry_hi_asid,
  output logic                    s_req,
  input  logic                    s_grant,
  output logic [18:0]             s_vpn2,
  output logic [7:0]              s_asid,
  input  logic                    s_found,
  input  logic [TLBNUM_WIDTH-1:0] s_index,
  output logic                    cp0_tlbp,
  output logic [TLBNUM_WIDTH:0]   cp0_tlbp_result,
  output logic                    cp0_tlbr,
  output logic                    cp0_tlbwr,
  output logic                    tlb_we,
  output logic                    refetch_req,
  output logic [31:0]             refetch_pc,
  input  logic                    refetch_ack
);

  typedef enum logic [2:0] {
    IDLE, PROBE, PROBE_WB, READ, WRITE, SETTLE, REFETCH
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(WRITE_SETTLE);

  state_t     state, state_nxt, post_strobe;
  logic [1:0] op_code_q;
  logic [3:0] settle_cnt;
  logic       accept;

  assign accept   = op_valid && (state == IDLE) && !flush;
  assign s_vpn2   = entry_hi_vpn2;
  assign s_asid   = entry_hi_asid;
  assign busy     = ~op_ready;

  // A one-cycle settle skips SETTLE entirely so the refetch follows the strobe directly.
  assign post_strobe = (WRITE_SETTLE == 1) ? REFETCH : SETTLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      op_code_q       <= 2'b00;
      refetch_pc      <= 32'h0;
      cp0_tlbp_result <= {1'b1, {TLBNUM_WIDTH{1'b0}}};
      settle_cnt      <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_code_q  <= op_code;
        refetch_pc <= op_pc + 32'd4;
      end
      if (state == PROBE && s_grant)
        cp0_tlbp_result <= {~s_found, s_found ? s_index : {TLBNUM_WIDTH{1'b0}}};
      if (state == READ || state == WRITE)
        settle_cnt <= SETTLE_LD;
      else if (state == SETTLE)
        settle_cnt <= settle_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    op_ready    = 1'b0;
    op_done     = 1'b0;
    s_req       = 1'b0;
    cp0_tlbp    = 1'b0;
    cp0_tlbr    = 1'b0;
    tlb_we      = 1'b0;
    cp0_tlbwr   = 1'b0;
    refetch_req = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (accept) begin
          case (op_code)
            2'b00:   state_nxt = PROBE;
            2'b01:   state_nxt = READ;
            default: state_nxt = WRITE;
          endcase
        end
      end
      PROBE: begin
        s_req = 1'b1;
        // A grant wins over a same-cycle flush: the probe result is already captured.
        if (s_grant)    state_nxt = PROBE_WB;
        else if (flush) state_nxt = IDLE;
      end
      PROBE_WB: begin
        cp0_tlbp  = 1'b1;
        op_done   = 1'b1;
        state_nxt = IDLE;
      end
      READ: begin
        cp0_tlbr  = 1'b1;
        state_nxt = post_strobe;
      end
      WRITE: begin
        tlb_we    = 1'b1;
        cp0_tlbwr = (op_code_q == 2'b11);
        state_nxt = post_strobe;
      end
      SETTLE: begin
        if (flush) begin
          op_done   = 1'b1;
          state_nxt = IDLE;
        end else if (settle_cnt <= 4'd2) begin
          state_nxt = REFETCH;
        end
      end
      REFETCH: begin
        refetch_req = 1'b1;
        if (flush || refetch_ack) begin
          op_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
